// File: rtl/spram_pkg.sv
// Shared constants, state encoding and helpers for the parametrised single-port RAM.
package spram_pkg;

   localparam int RDW_NO_CHANGE   = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_READ_FIRST  = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/spram_out_pipe.sv
// Valid/data delay line behind the array output register; data holds when no valid word passes.
module spram_out_pipe #(
   parameter int DW    = 8,
   parameter int DEPTH = 0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused;
         assign w_unused = i_clk ^ i_reset;
         assign o_valid  = i_valid;
         assign o_data   = i_data;
      end else begin : g_pipe
         logic [DEPTH-1:0]         r_vld;
         logic [DEPTH-1:0][DW-1:0] r_dat;
         logic [DEPTH-1:0]         w_pv;
         logic [DEPTH-1:0][DW-1:0] w_pd;

         // w_pv/w_pd[i] is what feeds stage i
         always_comb begin
            w_pv    = '0;
            w_pd    = '0;
            w_pv[0] = i_valid;
            w_pd[0] = i_data;
            for (int i = 1; i < DEPTH; i++) begin
               w_pv[i] = r_vld[i-1];
               w_pd[i] = r_dat[i-1];
            end
         end

         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_vld <= '0;
               r_dat <= '0;
            end else begin
               r_vld <= w_pv;
               for (int i = 0; i < DEPTH; i++)
                  if (w_pv[i]) r_dat[i] <= w_pd[i];
            end
         end

         assign o_valid = r_vld[DEPTH-1];
         assign o_data  = r_dat[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/spram_param_clr.sv
// Parametrised single-port RAM with lane write enables, selectable read-during-write,
// configurable read latency and a zero-fill clear sweep.
module spram_param_clr
   import spram_pkg::*;
#(
   parameter int AWIDTH         = 12,
   parameter int NUM_WORDS      = 4096,
   parameter int DWIDTH         = 60,
   parameter int NUM_LANES      = 4,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [AWIDTH-1:0]    address,
   input  logic                 wren,
   input  logic                 rden,
   input  logic [NUM_LANES-1:0] byte_en,
   input  logic [DWIDTH-1:0]    data,
   output logic [DWIDTH-1:0]    out,
   output logic                 out_valid,
   input  logic                 clear_req,
   output logic                 busy
);

   localparam int                LANE_W = DWIDTH / NUM_LANES;
   localparam logic [AWIDTH-1:0] LAST   = AWIDTH'(NUM_WORDS - 1);

   state_t              r_state, w_next;
   logic [AWIDTH-1:0]   r_clr_addr;
   logic [DWIDTH-1:0]   r_mem [NUM_WORDS];
   logic                r_s1_vld;
   logic [DWIDTH-1:0]   r_s1_data;
   logic                w_in_range, w_wr_acc, w_rd_acc, w_s1_vld;
   logic [DWIDTH-1:0]   w_old, w_merged, w_s1_word;

   always_ff @(posedge clk) begin
      if (reset) r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (clear_req) w_next = CLEAR;
         CLEAR:   if (r_clr_addr == LAST) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                r_clr_addr <= '0;
      else if (r_state == CLEAR) r_clr_addr <= (r_clr_addr == LAST) ? '0 : r_clr_addr + AWIDTH'(1);
   end

   assign busy       = (r_state == CLEAR);
   assign w_in_range = (32'(address) < 32'(NUM_WORDS));
   assign w_wr_acc   = (r_state == IDLE) && wren;
   assign w_rd_acc   = (r_state == IDLE) && rden && !wren;

   // Out-of-range accesses read as zero instead of aliasing into the array
   always_comb begin
      w_old    = w_in_range ? r_mem[address] : '0;
      w_merged = w_old;
      for (int i = 0; i < NUM_LANES; i++)
         if (byte_en[i]) w_merged[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == CLEAR)          r_mem[r_clr_addr] <= '0;
         else if (w_wr_acc && w_in_range) r_mem[address]  <= w_merged;
      end
   end

   assign w_s1_vld  = w_rd_acc || (w_wr_acc && (RDW_MODE != RDW_NO_CHANGE));
   assign w_s1_word = (w_wr_acc && (RDW_MODE == RDW_WRITE_FIRST) && w_in_range) ? w_merged : w_old;

   // Array output register (stage 1); holds its word between valid accesses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
      end else begin
         r_s1_vld <= w_s1_vld;
         if (w_s1_vld) r_s1_data <= w_s1_word;
      end
   end

   spram_out_pipe #(
      .DW    (DWIDTH),
      .DEPTH (READ_LATENCY - 1)
   ) u_out_pipe (
      .i_clk   (clk),
      .i_reset (reset),
      .i_valid (r_s1_vld),
      .i_data  (r_s1_data),
      .o_valid (out_valid),
      .o_data  (out)
   );

endmodule

// File: tb/tb_spram_param_clr.sv
// Directed bench over five RAM configurations: clear-on-reset, the three RDW modes,
// read latency 3 and a non-power-of-two depth.
module tb_spram_param_clr;

   localparam int N = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   wren_a, rden_a, clr_a;
   logic [3:0]     addr_a [N];
   logic [3:0]     be_a   [N];
   logic [59:0]    d_a    [N];
   wire  [59:0]    out_a  [N];
   wire  [N-1:0]   vld_a, busy_a;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          k;
      logic        wr;
      logic        rd;
      logic [3:0]  a;
      logic [3:0]  be;
      logic [59:0] d;
      logic        ev;
      logic [59:0] eo;
   } vec_t;

   vec_t tv[$];

   always #5 clk = ~clk;

   // 0: NO_CHANGE + clear on reset, 1: WRITE_FIRST, 2: READ_FIRST, 3: latency 3, 4: 12 words
   for (genvar g = 0; g < N; g++) begin : g_dut
      spram_param_clr #(
         .AWIDTH         (4),
         .NUM_WORDS      ((g == 4) ? 12 : 16),
         .DWIDTH         (60),
         .NUM_LANES      (4),
         .READ_LATENCY   ((g == 3) ? 3 : 1),
         .RDW_MODE       ((g == 1 || g == 4) ? 1 : ((g == 2) ? 2 : 0)),
         .CLEAR_ON_RESET ((g == 0) ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .address   (addr_a[g]),
         .wren      (wren_a[g]),
         .rden      (rden_a[g]),
         .byte_en   (be_a[g]),
         .data      (d_a[g]),
         .out       (out_a[g]),
         .out_valid (vld_a[g]),
         .clear_req (clr_a[g]),
         .busy      (busy_a[g])
      );
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int k, input logic wr, input logic rd, input logic clr,
                      input logic [3:0] a, input logic [3:0] be, input logic [59:0] d);
      wren_a[k] = wr;
      rden_a[k] = rd;
      clr_a[k]  = clr;
      addr_a[k] = a;
      be_a[k]   = be;
      d_a[k]    = d;
      @(posedge clk);
      #1;
      wren_a[k] = 1'b0;
      rden_a[k] = 1'b0;
      clr_a[k]  = 1'b0;
   endtask

   function automatic void add(input int k, input logic wr, input logic rd, input logic [3:0] a,
                               input logic [3:0] be, input logic [59:0] d,
                               input logic ev, input logic [59:0] eo);
      tv.push_back(vec_t'{k, wr, rd, a, be, d, ev, eo});
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          cnt;
      int          nv;
      logic [59:0] got [2];
      logic        ev3 [6];
      logic [59:0] eo3 [6];

      wren_a = '0; rden_a = '0; clr_a = '0;
      for (int k = 0; k < N; k++) begin
         addr_a[k] = '0; be_a[k] = '0; d_a[k] = '0;
      end

      // u0: NO_CHANGE, starts from the zero-filled array
      add(0, 0, 1, 4'd5, 4'hF, 60'h0,                 1, 60'h0);
      add(0, 1, 0, 4'd3, 4'hF, 60'hFFFFFFFFFFFFFFF,   0, 60'h0);
      add(0, 1, 0, 4'd3, 4'h5, 60'h0,                 0, 60'h0);
      add(0, 0, 1, 4'd3, 4'hF, 60'h0,                 1, 60'hFFFE0003FFF8000);
      add(0, 1, 0, 4'd7, 4'hF, 60'h123,               0, 60'hFFFE0003FFF8000);
      add(0, 0, 1, 4'd7, 4'hF, 60'h0,                 1, 60'h123);
      add(0, 1, 0, 4'd7, 4'hF, 60'h456,               0, 60'h123);
      add(0, 0, 1, 4'd7, 4'hF, 60'h0,                 1, 60'h456);
      add(0, 1, 0, 4'd9, 4'h0, 60'h777,               0, 60'h456);
      add(0, 0, 1, 4'd9, 4'hF, 60'h0,                 1, 60'h0);
      add(0, 1, 1, 4'd7, 4'hF, 60'h789,               0, 60'h0);
      add(0, 0, 1, 4'd7, 4'hF, 60'h0,                 1, 60'h789);
      // u1: WRITE_FIRST returns merged word
      add(1, 1, 0, 4'd7, 4'hF, 60'h123,               1, 60'h123);
      add(1, 1, 0, 4'd7, 4'hF, 60'h456,               1, 60'h456);
      add(1, 1, 0, 4'd7, 4'h0, 60'h999,               1, 60'h456);
      add(1, 1, 0, 4'd7, 4'h1, 60'hAAA,               1, 60'hAAA);
      add(1, 0, 1, 4'd7, 4'hF, 60'h0,                 1, 60'hAAA);
      // u2: READ_FIRST returns pre-write word
      add(2, 1, 0, 4'd7, 4'hF, 60'h123,               1, 60'h0);
      add(2, 1, 0, 4'd7, 4'hF, 60'h456,               1, 60'h123);
      add(2, 0, 1, 4'd7, 4'hF, 60'h0,                 1, 60'h456);
      // u4: 12 words, out-of-range and last-word boundary
      add(4, 1, 0, 4'd1,  4'hF, 60'h111,              1, 60'h111);
      add(4, 1, 0, 4'd13, 4'hF, 60'hABC,              1, 60'h0);
      add(4, 0, 1, 4'd13, 4'hF, 60'h0,                1, 60'h0);
      add(4, 0, 1, 4'd1,  4'hF, 60'h0,                1, 60'h111);
      add(4, 1, 0, 4'd11, 4'hF, 60'h5,                1, 60'h5);
      add(4, 0, 1, 4'd11, 4'hF, 60'h0,                1, 60'h5);
      add(4, 0, 1, 4'd12, 4'hF, 60'h0,                1, 60'h0);

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("rst_out%0d", k), out_a[k], 60'h0);
         chk($sformatf("rst_vld%0d", k), vld_a[k], 1'b0);
      end
      chk("rst_busy0", busy_a[0], 1'b1);
      chk("rst_busy1", busy_a[1], 1'b0);

      // Clear-on-reset sweep on u0; the other instances are zero-filled via clear_req
      reset = 1'b0;
      clr_a = 5'b11110;
      cnt   = 0;
      while (busy_a[0] && cnt < 100) begin
         cnt++;
         @(posedge clk);
         #1;
         clr_a = '0;
      end
      chk("sweep_len", cnt, 16);
      repeat (4) @(posedge clk);
      #1;
      chk("all_idle", busy_a, 5'b0);

      foreach (tv[i]) begin
         cyc(tv[i].k, tv[i].wr, tv[i].rd, 1'b0, tv[i].a, tv[i].be, tv[i].d);
         chk($sformatf("vec%0d_vld", i), vld_a[tv[i].k], tv[i].ev);
         chk($sformatf("vec%0d_out", i), out_a[tv[i].k], tv[i].eo);
      end

      // Latency 3: back-to-back reads
      cyc(3, 1, 0, 0, 4'd0, 4'hF, 60'd10);
      cyc(3, 1, 0, 0, 4'd1, 4'hF, 60'd11);
      cyc(3, 1, 0, 0, 4'd2, 4'hF, 60'd12);
      ev3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      eo3 = '{60'd0, 60'd0, 60'd10, 60'd11, 60'd12, 60'd12};
      for (int i = 0; i < 6; i++) begin
         if (i < 3) cyc(3, 0, 1, 0, 4'(i), 4'hF, 60'h0);
         else       cyc(3, 0, 0, 0, 4'd0, 4'hF, 60'h0);
         chk($sformatf("rl3_vld%0d", i), vld_a[3], ev3[i]);
         chk($sformatf("rl3_out%0d", i), out_a[3], eo3[i]);
      end

      // Clear requested with reads in flight, reads issued while busy
      cyc(3, 1, 0, 0, 4'd4, 4'hF, 60'h44);
      cyc(3, 0, 1, 0, 4'd0, 4'hF, 60'h0);
      chk("clr_pre_vld", vld_a[3], 1'b0);
      cyc(3, 0, 1, 1, 4'd1, 4'hF, 60'h0);
      chk("clr_busy", busy_a[3], 1'b1);
      cnt = 0;
      nv  = 0;
      got = '{60'h0, 60'h0};
      while (busy_a[3] && cnt < 40) begin
         cyc(3, 0, 1, 0, 4'd4, 4'hF, 60'h0);
         cnt++;
         if (vld_a[3]) begin
            if (nv < 2) got[nv] = out_a[3];
            nv++;
         end
      end
      chk("clr_busy_len", cnt, 16);
      chk("clr_inflight_cnt", nv, 2);
      chk("clr_inflight0", got[0], 60'd10);
      chk("clr_inflight1", got[1], 60'd11);
      cyc(3, 0, 1, 0, 4'd4, 4'hF, 60'h0);
      chk("post_clr_vld0", vld_a[3], 1'b0);
      cyc(3, 0, 0, 0, 4'd0, 4'hF, 60'h0);
      chk("post_clr_vld1", vld_a[3], 1'b0);
      cyc(3, 0, 0, 0, 4'd0, 4'hF, 60'h0);
      chk("post_clr_vld2", vld_a[3], 1'b1);
      chk("post_clr_out", out_a[3], 60'h0);

      // wren + rden + clear_req together: write serviced, read ignored, then sweep
      cyc(1, 1, 1, 1, 4'd2, 4'hF, 60'h22);
      chk("triple_vld", vld_a[1], 1'b1);
      chk("triple_out", out_a[1], 60'h22);
      chk("triple_busy", busy_a[1], 1'b1);
      cnt = 0;
      while (busy_a[1] && cnt < 40) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      chk("triple_busy_len", cnt, 16);
      cyc(1, 0, 1, 0, 4'd2, 4'hF, 60'h0);
      chk("triple_post_vld", vld_a[1], 1'b1);
      chk("triple_post_out", out_a[1], 60'h0);

      // Reset mid-sweep restarts the full sweep on u0
      cyc(0, 0, 0, 1, 4'd0, 4'hF, 60'h0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out", out_a[0], 60'h0);
      chk("midrst_busy", busy_a[0], 1'b1);
      reset = 1'b0;
      cnt   = 0;
      while (busy_a[0] && cnt < 100) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      chk("midrst_sweep_len", cnt, 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spram_param_clr.md
Name: spram_param_clr

Overview:
Parametrised single-port RAM for accelerator scratchpads and weight buffers. Generalises the fixed 4096x60 single-port RAM: configurable depth/width, per-lane write enables, selectable read-during-write behaviour, configurable read latency with an aligned valid strobe, and a hardware clear engine. Sits between compute-tile controllers and on-chip storage. One instance per buffer.

Parameters:
AWIDTH, 12, address width
NUM_WORDS, 4096, depth; must be <= 2**AWIDTH
DWIDTH, 60, word width
NUM_LANES, 4, write-enable lanes; DWIDTH % NUM_LANES == 0; LANE_W = DWIDTH/NUM_LANES
READ_LATENCY, 1, cycles from accepted access to out_valid; legal 1..4
RDW_MODE, 0, 0=NO_CHANGE, 1=WRITE_FIRST, 2=READ_FIRST
CLEAR_ON_RESET, 0, 1 = run clear sweep automatically after reset

Ports:
clk  in  1  sole clock, all logic on posedge
reset  in  1  synchronous, active-high
address  in  AWIDTH  word address
wren  in  1  write request
rden  in  1  read request
byte_en  in  NUM_LANES  per-lane write enable; lane i = bits [i*LANE_W +: LANE_W]
data  in  DWIDTH  write data
out  out  DWIDTH  read data, holds last valid value
out_valid  out  1  one-cycle pulse per returned word
clear_req  in  1  start zero-fill sweep
busy  out  1  clear sweep in progress; accesses dropped

Behaviour:
- Reset: out=0, out_valid=0, read pipeline flushed, clr_addr=0. state <= CLEAR if CLEAR_ON_RESET, else IDLE. busy is registered (state==CLEAR), so busy=1 from the first cycle after reset deasserts. Array contents are not reset.
- IDLE + clear_req: enter CLEAR next cycle. busy=1. wren/rden in the clear_req cycle are still serviced.
- CLEAR: each cycle writes 0 to ram[clr_addr], then clr_addr++. The cycle writing NUM_WORDS-1 returns to IDLE. Sweep is exactly NUM_WORDS cycles. clear_req is ignored while in CLEAR.
- While busy, wren/rden are dropped silently: no write, no out_valid.
- Reset mid-sweep aborts it and flushes the pipeline. If CLEAR_ON_RESET=1, the sweep restarts at 0.
- Access in IDLE: wren has priority over rden.
- Write: each lane with byte_en[i]=1 is updated; other lanes are kept.
- wren with byte_en=0 is a no-op write but still follows RDW_MODE for output.
- Pure read (rden & !wren): returns ram[address].
- Write cycle output depends on RDW_MODE:
  - NO_CHANGE: no out_valid; out holds.
  - WRITE_FIRST: returns the merged post-write word, out_valid.
  - READ_FIRST: returns the pre-write word, out_valid.
- Latency: array output register is stage 1; READ_LATENCY-1 further pipeline stages follow. An access accepted in cycle t produces out/out_valid in cycle t+READ_LATENCY. Throughput is one access per cycle. out updates only when a valid word emerges.
- Out-of-range address (>= NUM_WORDS): write dropped. Read/RDW returns 0 with out_valid.
- Simultaneous wren, rden, clear_req in IDLE: write serviced, read ignored, CLEAR entered next cycle.

Decomposition:
- Package spram_pkg: RDW_NO_CHANGE/RDW_WRITE_FIRST/RDW_READ_FIRST constants; state enum IDLE/CLEAR; clog2 helper.
- Sub-module spram_out_pipe: parametrised DWIDTH+1-bit delay line (depth READ_LATENCY-1, reset clears valid bits). Instantiated once; a depth of 0 is a wire-through.

Test Plan:
1. NUM_WORDS=16, CLEAR_ON_RESET=1, reset held 2 cycles -> busy=1 for exactly 16 cycles. Then read addr 5 -> out=0, out_valid at t+READ_LATENCY.
2. Write all-ones to addr 3 with byte_en=4'b1111. Write 0 with byte_en=4'b0101. Read addr 3 -> out=60'hFFFE0003FFF8000.
3. Addr 7 holds 60'h123. Write 60'h456 to addr 7 under each RDW_MODE:
   - NO_CHANGE -> no out_valid, out unchanged.
   - WRITE_FIRST -> out=60'h456.
   - READ_FIRST -> out=60'h123.
4. READ_LATENCY=3: back-to-back reads of addrs 0,1,2 (preloaded 10,11,12) -> out_valid high for 3 consecutive cycles starting t+3, values 10,11,12.
5. clear_req mid-stream with reads pending -> in-flight reads still return. Reads issued while busy produce no out_valid. A post-clear read of a previously written address returns 0.
6. NUM_WORDS=12, AWIDTH=4: write 60'hABC to addr 13, then read addr 13 -> out=0 with out_valid. ram[1] is unchanged.
